// File: rtl/gpio_arb_pkg.sv
// gpio_arb_pkg: shared types and widths for the gpio_regs port arbiter.
// Provides the FSM state type, bus widths and an index-width helper.
package gpio_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int ARB_BE_W   = 4;

    // Width able to hold 0..n-1; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpio_rr_arbiter.sv
// gpio_rr_arbiter: combinational round-robin pick.
// First asserted request at or after ptr, wrapping, wins.
module gpio_rr_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scan requests starting from the pointer position.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (!any && req[(int'(ptr) + i) % N]) begin
                any = 1'b1;
                idx = IW'((int'(ptr) + i) % N);
            end
        end
        gnt = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// gpio_reg_arbiter: shares one gpio_regs port among NUM_REQ requesters.
// Optional owner lock for read-modify-write: define GPIO_ARB_LOCK_EN.
module gpio_reg_arbiter
    import gpio_arb_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ARB_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*ARB_DATA_W-1:0] req_wdata,
    input  logic [NUM_REQ*ARB_BE_W-1:0]   req_be,
`ifdef GPIO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            req_lock,
`endif
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [ARB_DATA_W-1:0]         rsp_rdata,
    output logic                          rsp_err,
    output logic [ARB_ADDR_W-1:0]         addr,
    output logic [ARB_DATA_W-1:0]         wdata,
    output logic [ARB_BE_W-1:0]           be,
    output logic                          we,
    output logic                          re,
    input  logic                          ack,
    input  logic [ARB_DATA_W-1:0]         rdata
);

    localparam int IW = idx_w(NUM_REQ);
    localparam int CW = idx_w(TIMEOUT_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    arb_state_t            state_q, state_d;
    logic [IW-1:0]         ptr_q, ptr_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic                  wr_q, wr_d;
    logic [ARB_ADDR_W-1:0] addr_q, addr_d;
    logic [ARB_DATA_W-1:0] wdata_q, wdata_d;
    logic [ARB_BE_W-1:0]   be_q, be_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ARB_DATA_W-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [NUM_REQ-1:0]    elig;
    logic [NUM_REQ-1:0]    gnt;
    logic [IW-1:0]         win;
    logic                  win_any;
    logic [NUM_REQ-1:0]    owner_oh;

    assign owner_oh = NUM_REQ'(1) << owner_q;

`ifdef GPIO_ARB_LOCK_EN
    logic                  lock_q, lock_d;
    logic [CW-1:0]         lcnt_q, lcnt_d;
    assign elig = lock_q ? (req_valid & owner_oh) : req_valid;
`else
    assign elig = req_valid;
`endif

    gpio_rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req (elig),
        .ptr (ptr_q),
        .gnt (gnt),
        .idx (win),
        .any (win_any)
    );

    // Grants never leak while reset holds the capture registers.
    assign req_ready = (state_q == ARB_IDLE && reset_n) ? gnt : '0;
    assign rsp_valid = (state_q == ARB_RESP) ? owner_oh : '0;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign be        = be_q;
    assign we        = (state_q == ARB_BUSY) && wr_q;
    assign re        = (state_q == ARB_BUSY) && !wr_q;

    // Next-state, capture and timeout logic for the transaction FSM.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        cnt_d   = '0;
        rdata_d = rdata_q;
        err_d   = err_q;
`ifdef GPIO_ARB_LOCK_EN
        lock_d  = lock_q;
        lcnt_d  = '0;
`endif
        unique case (state_q)
            ARB_IDLE: begin
`ifdef GPIO_ARB_LOCK_EN
                if (lock_q && !req_valid[owner_q]) begin
                    if (lcnt_q == CNT_LAST) begin
                        lock_d = 1'b0;
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
`endif
                if (win_any) begin
                    state_d = ARB_BUSY;
                    owner_d = win;
                    wr_d    = req_we[win];
                    addr_d  = req_addr[int'(win)*ARB_ADDR_W +: ARB_ADDR_W];
                    wdata_d = req_wdata[int'(win)*ARB_DATA_W +: ARB_DATA_W];
                    be_d    = req_be[int'(win)*ARB_BE_W +: ARB_BE_W];
`ifdef GPIO_ARB_LOCK_EN
                    lock_d  = req_lock[win];
                    if (!req_lock[win]) begin
                        ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
                    end
`else
                    ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
`endif
                end
            end
            ARB_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (ack) begin
                    state_d = ARB_RESP;
                    rdata_d = wr_q ? '0 : rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ARB_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State and capture registers; reset aborts any transaction silently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

`ifdef GPIO_ARB_LOCK_EN
    // Owner lock and its idle-release counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_q <= 1'b0;
            lcnt_q <= '0;
        end else begin
            lock_q <= lock_d;
            lcnt_q <= lcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// tb_gpio_reg_arbiter: directed self-checking bench for gpio_reg_arbiter.
// Inputs change 1ns after posedge; outputs are checked 2ns after posedge.
module tb_gpio_reg_arbiter;

    localparam int N  = 2;
    localparam int TO = 16;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*32-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N*4-1:0]  req_be;
`ifdef GPIO_ARB_LOCK_EN
    logic [N-1:0]    req_lock;
`endif
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [3:0]      be;
    logic            we;
    logic            re;
    logic            ack;
    logic [31:0]     rdata;

    int checks;
    int errors;

    gpio_reg_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
`ifdef GPIO_ARB_LOCK_EN
        .req_lock  (req_lock),
`endif
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addr      (addr),
        .wdata     (wdata),
        .be        (be),
        .we        (we),
        .re        (re),
        .ack       (ack),
        .rdata     (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_we    = '0;
        ack       = 1'b0;
        rdata     = '0;
`ifdef GPIO_ARB_LOCK_EN
        req_lock  = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        do_reset();

        // reset state
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_rspv", 32'(rsp_valid), 0);
        chk("rst_were", 32'({we, re}), 0);
        chk("rst_addr", addr, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", 32'(rsp_err), 0);

        // single read from requester 0
        step();
        req_valid = 2'b01;
        req_we    = 2'b00;
        req_addr[31:0] = 32'h04;
        req_be[3:0]    = 4'hF;
        #1;
        chk("rd_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        ack   = 1'b1;
        rdata = 32'hA5A5_0001;
        #1;
        chk("rd_re", 32'({we, re}), 32'h1);
        chk("rd_addr", addr, 32'h04);
        chk("rd_busy_ready", 32'(req_ready), 0);
        step();
        ack = 1'b0;
        #1;
        chk("rd_rspv", 32'(rsp_valid), 32'h1);
        chk("rd_rdata", rsp_rdata, 32'hA5A5_0001);
        chk("rd_err", 32'(rsp_err), 0);
        chk("rd_resp_re", 32'(re), 0);

        // contention: req0 writes 0x10, req1 reads 0x20, both held valid
        do_reset();
        req_valid = 2'b11;
        req_we    = 2'b01;
        req_addr  = {32'h20, 32'h10};
        req_wdata = {32'h0, 32'h55};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("ct_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            step();
            ack   = 1'b1;
            rdata = 32'h100 + 32'(k);
            #1;
            chk("ct_were", 32'({we, re}), (k % 2 == 0) ? 32'h2 : 32'h1);
            chk("ct_addr", addr, (k % 2 == 0) ? 32'h10 : 32'h20);
            step();
            ack = 1'b0;
            #1;
            chk("ct_rspv", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("ct_rdata", rsp_rdata, (k % 2 == 0) ? 32'h0 : 32'h100 + 32'(k));
            step();
        end

        // write timeout on requester 0
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr[31:0]  = 32'h08;
        req_wdata[31:0] = 32'h1234;
        #1;
        chk("to_ready", 32'(req_ready), 32'h1);
        n = 0;
        for (int i = 0; i < TO; i++) begin
            step();
            req_valid = '0;
            #1;
            if (we) n++;
        end
        chk("to_we_cycles", 32'(n), 32'(TO));
        step();
        #1;
        chk("to_we_low", 32'({we, re}), 0);
        chk("to_rspv", 32'(rsp_valid), 32'h1);
        chk("to_err", 32'(rsp_err), 32'h1);
        chk("to_rdata", rsp_rdata, 0);
        step();

        // ack on the last BUSY cycle beats the timeout (requester 1 read)
        req_valid = 2'b10;
        req_we    = 2'b00;
        req_addr[63:32] = 32'h0C;
        #1;
        chk("at_ready", 32'(req_ready), 32'h2);
        for (int i = 0; i < TO; i++) begin
            step();
            req_valid = '0;
            if (i == TO - 1) begin
                ack   = 1'b1;
                rdata = 32'hDEAD_BEEF;
            end
            #1;
        end
        step();
        ack = 1'b0;
        #1;
        chk("at_rspv", 32'(rsp_valid), 32'h2);
        chk("at_err", 32'(rsp_err), 0);
        chk("at_rdata", rsp_rdata, 32'hDEAD_BEEF);
        step();

        // reset during BUSY
        req_valid = 2'b01;
        req_addr[31:0] = 32'h44;
        #1;
        chk("rm_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        #1;
        chk("rm_busy_re", 32'(re), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rm_were", 32'({we, re}), 0);
        chk("rm_addr", addr, 0);
        chk("rm_rspv", 32'(rsp_valid), 0);
        step();
        #1;
        chk("rm_rspv_hold", 32'(rsp_valid), 0);
        reset_n   = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rm_ptr0", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();

`ifdef GPIO_ARB_LOCK_EN
        // locked read then unlocked write by req0; req1 waits
        do_reset();
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_lock  = 2'b01;
        #1;
        chk("lk_first", 32'(req_ready), 32'h1);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        req_lock = 2'b00;
        req_we   = 2'b01;
        #1;
        chk("lk_owner", 32'(req_ready), 32'h1);
        step();
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        #1;
        chk("lk_release", 32'(req_ready), 32'h2);
        req_valid = '0;
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
